// File: rtl/sequenciador_notas.sv
// Note sequencer: walks a 64-entry song in a synchronous note ROM, holding
// each note for dur*TICKS_PER_UNIT unpaused cycles.
module sequenciador_notas #(
  parameter int TICKS_PER_UNIT = 12500000,
  parameter int LOOP           = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] select,
  input  logic       pause,
  output logic [7:0] rom_addr,
  input  logic [9:0] rom_data,
  output logic [5:0] note,
  output logic       note_valid,
  output logic       busy,
  output logic       song_end
);

  localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_END
  } state_t;

  state_t        state;
  logic [1:0]    song;
  logic [5:0]    idx;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    unit_cnt;
  logic [3:0]    dur_reg;
  logic [5:0]    note_reg;

  // note_reg keeps the last captured code; it is only presented while playing.
  assign note       = (state == S_PLAY) ? note_reg : 6'd0;
  assign note_valid = (state == S_PLAY) && !pause && (note_reg != 6'd0);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      song     <= 2'd0;
      idx      <= 6'd0;
      tick_cnt <= '0;
      unit_cnt <= 4'd0;
      dur_reg  <= 4'd0;
      note_reg <= 6'd0;
      rom_addr <= 8'd0;
      song_end <= 1'b0;
    end else begin
      song_end <= 1'b0;
      if (start) begin
        state    <= S_FETCH;
        song     <= select;
        idx      <= 6'd0;
        tick_cnt <= '0;
        unit_cnt <= 4'd0;
        rom_addr <= {select, 6'd0};
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            note_reg <= rom_data[9:4];
            dur_reg  <= rom_data[3:0];
            tick_cnt <= '0;
            unit_cnt <= 4'd0;
            if (rom_data[3:0] == 4'd0) begin
              state    <= S_END;
              song_end <= 1'b1;
            end else begin
              state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!pause) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (unit_cnt == dur_reg - 4'd1) begin
                  unit_cnt <= 4'd0;
                  if (idx == 6'd63) begin
                    state    <= S_END;
                    song_end <= 1'b1;
                  end else begin
                    idx      <= idx + 6'd1;
                    rom_addr <= {song, idx + 6'd1};
                    state    <= S_FETCH;
                  end
                end else begin
                  unit_cnt <= unit_cnt + 4'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          S_END: begin
            if (LOOP != 0) begin
              state    <= S_FETCH;
              idx      <= 6'd0;
              rom_addr <= {song, 6'd0};
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_notas.sv
// Bench for sequenciador_notas: one non-looping and one looping instance share
// a ROM image and are compared every cycle against a slot-position model.
module tb_sequenciador_notas;

  localparam int TPU = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] select = 2'd0;
  logic       pause = 1'b0;

  logic [7:0] rom_addr0, rom_addr1;
  logic [9:0] rom_data0, rom_data1;
  logic [5:0] note0, note1;
  logic       note_valid0, note_valid1, busy0, busy1, song_end0, song_end1;

  logic [9:0] rom [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequenciador_notas #(.TICKS_PER_UNIT(TPU), .LOOP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .select(select), .pause(pause),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .note(note0),
    .note_valid(note_valid0), .busy(busy0), .song_end(song_end0)
  );

  sequenciador_notas #(.TICKS_PER_UNIT(TPU), .LOOP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .select(select), .pause(pause),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .note(note1),
    .note_valid(note_valid1), .busy(busy1), .song_end(song_end1)
  );

  always_ff @(posedge clk) begin
    rom_data0 <= rom[rom_addr0];
    rom_data1 <= rom[rom_addr1];
  end

  // Model: a song is a sequence of slots; each slot is fetch (pos 0), wait
  // (pos 1), then dur*TPU sounding positions that only advance when unpaused.
  typedef struct {
    bit       act;
    bit       ending;
    bit [1:0] song;
    bit [5:0] idx;
    int       pos;
    bit [5:0] n;
    bit [3:0] d;
    bit [7:0] addr;
  } model_t;

  model_t m0 = '{default: 0};
  model_t m1 = '{default: 0};
  bit     m_ok = 1'b0;

  function automatic model_t step(model_t m, bit loop_en, bit rst, bit st,
                                  bit [1:0] sel, bit ps);
    model_t r = m;
    if (rst) begin
      r = '{default: 0};
    end else if (st) begin
      r.act = 1; r.ending = 0; r.song = sel; r.idx = 0; r.pos = 0;
      r.addr = {sel, 6'd0};
    end else if (!m.act) begin
      r = m;
    end else if (m.ending) begin
      r.ending = 0;
      if (loop_en) begin
        r.idx = 0; r.pos = 0; r.addr = {m.song, 6'd0};
      end else begin
        r.act = 0;
      end
    end else if (m.pos == 0) begin
      r.pos = 1;
    end else if (m.pos == 1) begin
      r.n = rom[{m.song, m.idx}][9:4];
      r.d = rom[{m.song, m.idx}][3:0];
      if (r.d == 0) r.ending = 1;
      else r.pos = 2;
    end else if (!ps) begin
      if (m.pos == 1 + int'(m.d) * TPU) begin
        if (m.idx == 6'd63) begin
          r.ending = 1;
        end else begin
          r.idx = m.idx + 6'd1; r.pos = 0; r.addr = {m.song, r.idx};
        end
      end else begin
        r.pos = m.pos + 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, 1'b0, reset, start, select, pause);
    m1 <= step(m1, 1'b1, reset, start, select, pause);
    if (reset) m_ok <= 1'b1;
  end

  task automatic expect_eq(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input model_t m, input logic [7:0] a,
                         input logic [5:0] n, input logic nv, input logic b,
                         input logic se);
    logic [5:0] en;
    en = (m.act && !m.ending && m.pos >= 2) ? m.n : 6'd0;
    expect_eq({tag, "_rom_addr"}, 32'(a), 32'(m.addr));
    expect_eq({tag, "_note"}, 32'(n), 32'(en));
    expect_eq({tag, "_note_valid"}, 32'(nv), 32'((en != 0) && !pause));
    expect_eq({tag, "_busy"}, 32'(b), 32'(m.act));
    expect_eq({tag, "_song_end"}, 32'(se), 32'(m.ending));
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      cmp_dut("d0", m0, rom_addr0, note0, note_valid0, busy0, song_end0);
      cmp_dut("d1", m1, rom_addr1, note1, note_valid1, busy1, song_end1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 10'd0;
  endtask

  initial begin
    int cnt;
    clear_rom();
    do_reset(2);
    settle();
    expect_eq("reset_busy", 32'(busy0), 0);
    expect_eq("reset_rom_addr", 32'(rom_addr0), 0);
    expect_eq("reset_note", 32'(note0), 0);

    // Song 2 first note {10,2}: address, first-note latency, note length.
    do_reset(1);
    rom[8'h80] = {6'd10, 4'd2};
    rom[8'h81] = {6'd5, 4'd1};
    rom[8'h82] = {6'd0, 4'd0};
    select = 2'd2; start = 1'b1;
    tick(); start = 1'b0; settle();
    expect_eq("a_addr_t1", 32'(rom_addr0), 32'h80);
    tick(); tick(); settle();
    expect_eq("a_note_t3", 32'(note0), 10);
    expect_eq("a_nv_t3", 32'(note_valid0), 1);
    repeat (7) tick();
    settle();
    expect_eq("a_note_t10", 32'(note0), 10);
    expect_eq("a_nv_t10", 32'(note_valid0), 1);
    tick(); settle();
    expect_eq("a_addr_t11", 32'(rom_addr0), 32'h81);
    expect_eq("a_note_t11", 32'(note0), 0);

    // Song 0 ends on a dur=0 entry at idx 3.
    do_reset(1);
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = {6'(i + 1), 4'd1};
    rom[3] = {6'd0, 4'd0};
    select = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (20) tick();
    settle();
    expect_eq("b_song_end", 32'(song_end0), 1);
    tick(); settle();
    expect_eq("b_song_end_off", 32'(song_end0), 0);
    expect_eq("b_busy_off", 32'(busy0), 0);
    expect_eq("b_note_off", 32'(note0), 0);

    // Five paused cycles inside a dur=1 note delay the next fetch by five.
    do_reset(1);
    rom[8'h40] = {6'd7, 4'd1};
    rom[8'h41] = {6'd8, 4'd1};
    rom[8'h42] = {6'd0, 4'd0};
    select = 2'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); settle();
    expect_eq("c_nv_t3", 32'(note_valid0), 1);
    tick(); pause = 1'b1; settle();
    expect_eq("c_nv_paused", 32'(note_valid0), 0);
    expect_eq("c_note_paused", 32'(note0), 7);
    repeat (4) tick();
    tick(); pause = 1'b0;
    tick(); tick(); settle();
    expect_eq("c_note_t11", 32'(note0), 7);
    expect_eq("c_nv_t11", 32'(note_valid0), 1);
    tick(); settle();
    expect_eq("c_addr_t12", 32'(rom_addr0), 32'h41);

    // Restart into song 1 in the middle of a song 0 note.
    do_reset(1);
    rom[8'h00] = {6'd9, 4'd3};
    rom[8'h40] = {6'd4, 4'd2};
    select = 2'd0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    settle();
    expect_eq("d_note_before", 32'(note0), 9);
    select = 2'd1; start = 1'b1;
    tick(); start = 1'b0; select = 2'd3; settle();
    expect_eq("d_addr_restart", 32'(rom_addr0), 32'h40);
    expect_eq("d_note_dropped", 32'(note0), 0);

    // Two-cycle reset while song 1 is playing.
    repeat (4) tick();
    reset = 1'b1;
    tick(); tick(); reset = 1'b0; settle();
    expect_eq("e_busy", 32'(busy0), 0);
    expect_eq("e_note", 32'(note0), 0);
    expect_eq("e_addr", 32'(rom_addr0), 0);
    expect_eq("e_song_end", 32'(song_end0), 0);

    // Song 3 full of dur=1 entries; the looping instance wraps to 0xC0.
    do_reset(1);
    for (int i = 0; i < 64; i++) rom[8'hC0 + i] = {6'($urandom_range(0, 63)), 4'd1};
    select = 2'd3; start = 1'b1;
    tick(); start = 1'b0;
    cnt = 0;
    while (!song_end1 && cnt < 600) begin
      tick(); cnt++;
    end
    settle();
    expect_eq("f_song_end_seen", 32'(song_end1), 1);
    tick(); settle();
    expect_eq("f_loop_addr", 32'(rom_addr1), 32'hC0);
    expect_eq("f_loop_busy", 32'(busy1), 1);
    expect_eq("f_noloop_busy", 32'(busy0), 0);

    // Random ROM contents and random start/select/pause/reset traffic.
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      logic [5:0] nn;
      logic [3:0] dd;
      nn = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      dd = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      rom[i] = {nn, dd};
    end
    for (int c = 0; c < 5000; c++) begin
      int r;
      tick();
      r = $urandom_range(0, 999);
      reset = (r < 2);
      start = (r >= 2 && r < 15);
      select = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 3) == 0);
    end
    do_reset(1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequenciador_notas.md
SEQUENCIADOR_NOTAS -- requirements
Module: sequenciador_notas

Interface
REQ-001 The block SHALL have parameter TICKS_PER_UNIT, default 12500000, giving clock cycles per duration unit (0.25 s at 50 MHz).
REQ-002 The block SHALL have parameter LOOP, default 0; when set to 1, the song restarts at index 0 after its end.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to (re)start playback of the song on select; sampled every cycle.
REQ-006 The block SHALL have port select, input, 2 bits: song number, used only on cycles where start=1.
REQ-007 The block SHALL have port pause, input, 1 bit: level; freezes playback while high.
REQ-008 The block SHALL have port rom_addr, output, 8 bits, registered: note ROM address {song[1:0], idx[5:0]}.
REQ-009 The block SHALL have port rom_data, input, 10 bits: {note[5:0], dur[3:0]}; valid one cycle after rom_addr changes (synchronous ROM).
REQ-010 The block SHALL have port note, output, 6 bits: current note code; 0 means rest.
REQ-011 The block SHALL have port note_valid, output, 1 bit: high while a note is sounding and not paused.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port song_end, output, 1 bit: one-cycle pulse when a song finishes.

Function
REQ-014 The state machine SHALL have five states: IDLE, FETCH, WAIT, PLAY and END.
REQ-015 When start=1 in any state, the next state SHALL be FETCH, with song latched from select, idx=0 and all counters cleared; start has priority over every other condition.
REQ-016 Changes on select while start=0 SHALL be ignored.
REQ-017 While start is held high, the block SHALL remain in FETCH at idx 0.
REQ-018 FETCH SHALL drive rom_addr={song,idx} and always go to WAIT on the next cycle.
REQ-019 In WAIT, the block SHALL capture rom_data into note_reg/dur_reg; if dur=0, go to END, else go to PLAY.
REQ-020 PLAY SHALL last exactly dur*TICKS_PER_UNIT unpaused cycles, using tick_cnt (0..TICKS_PER_UNIT-1) and unit_cnt (0..dur-1).
REQ-021 On the last PLAY cycle, if idx=63 the block SHALL go to END; otherwise it SHALL increment idx and go to FETCH.
REQ-022 In PLAY with pause=1, the counters SHALL hold, note_valid=0 and note SHALL keep its value.
REQ-023 Pause SHALL have no effect in IDLE, FETCH, WAIT or END.
REQ-024 In END, song_end=1 for exactly one cycle; the next state SHALL be IDLE if LOOP=0, or FETCH with idx=0 and the same song if LOOP=1.
REQ-025 In PLAY, note_valid=1 exactly when pause=0 and note_reg is non-zero; a rest (note 0) SHALL hold note_valid=0 for its full duration.
REQ-026 In every state other than PLAY, note=0 and note_valid=0.
REQ-027 Latency SHALL be: start high in cycle T gives rom_addr valid in T+1 and first note on note/note_valid in T+3.
REQ-028 There SHALL be a one-FETCH/one-WAIT cycle gap (two cycles, note=0) between consecutive notes.

Reset
REQ-029 When reset=1 at a rising edge of clk, the next state SHALL be IDLE, with song=0, idx=0, counters=0, rom_addr=0, note=0, note_valid=0, busy=0 and song_end=0.
REQ-030 Reset SHALL take priority over start and pause, including in the middle of a note.

Verification (TICKS_PER_UNIT=4)
REQ-031 Assert reset for 2 cycles while playing -> next cycle all outputs are 0, busy=0 and the block is in IDLE.
REQ-032 With select=2, pulse start at T, and ROM[0x80]={10,2} -> rom_addr=0x80 at T+1; note=10 with note_valid=1 from T+3 to T+10; rom_addr=0x81 at T+11.
REQ-033 With ROM[0x03] dur=0 and song 0 -> after idx 2 ends, song_end=1 for one cycle, then busy=0 and note=0.
REQ-034 Hold pause=1 for 5 cycles during a dur=1 note -> note_valid=0 for those 5 cycles and the note ends 5 cycles late.
REQ-035 Pulse start with select=1 during PLAY of song 0 -> rom_addr=0x40 on the next cycle, and the old note drops to 0.
REQ-036 Fill song 3 with dur=1 in all 64 entries, LOOP=1 -> after idx 63, song_end pulses and rom_addr returns to 0xC0.
